quadrature_step_requester: RTL and testbench

Decodes a two-phase quadrature input (rotary encoder or jog switch pair) into single-step up/down requests for the up/down counter that sits directly downstream. It synchronizes the raw phases, rejects illegal transitions, and accumulates pending steps in a saturating signed counter. It then replays those steps one at a time over the counter's request/acknowledge handshake, so no edge is lost while the counter is busy acknowledging.

---
 rtl/quadrature_pkg.sv | 36 +++
 rtl/sync_bit.sv | 23 ++
 rtl/quadrature_step_requester.sv | 141 ++++++++++++++
 tb/tb_quadrature_step_requester.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_pkg.sv
// Shared encodings for the quadrature step requester:
// request-state values and Gray-decode step classes.
package quadrature_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        UP_REQ   = 2'b01,
        DOWN_REQ = 2'b10
    } req_state_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_FWD  = 2'b01,
        STEP_BAD  = 2'b10,
        STEP_REV  = 2'b11
    } step_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00
    function automatic step_t gray_decode(
        input logic [1:0] prev,
        input logic [1:0] cur
    );
        step_t s;
        case ({prev, cur})
            4'b0001, 4'b0111,
            4'b1110, 4'b1000: s = STEP_FWD;
            4'b0100, 4'b1101,
            4'b1011, 4'b0010: s = STEP_REV;
            4'b0011, 4'b1100,
            4'b0110, 4'b1001: s = STEP_BAD;
            default:          s = STEP_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Reset-to-zero flop chain bringing one asynchronous
// bit into the clock domain.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            chain <= '0;
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/quadrature_step_requester.sv
// Quadrature decoder that banks steps in a saturating
// counter and replays them over a req/ack handshake.
module quadrature_step_requester
    import quadrature_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int PENDING_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     quadA,
    input  logic                     quadB,
    input  logic                     upAck,
    input  logic                     downAck,
    output logic                     up,
    output logic                     down,
    output logic [PENDING_WIDTH-1:0] pending,
    output logic                     overflow,
    output logic                     glitch
);

    localparam int W = PENDING_WIDTH;

    logic              a_sync;
    logic              b_sync;
    logic [1:0]        prev_ab;
    step_t             step;
    req_state_t        state;
    logic signed [W-1:0] pend_q;
    logic signed [W-1:0] pend_base;
    logic signed [W-1:0] pend_next;
    logic signed [W:0]   step_ext;
    logic signed [W:0]   sum;
    logic              sat;
    logic              pos;
    logic              neg;
    logic              issue_up;
    logic              issue_down;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clock (clock),
        .reset (reset),
        .d     (quadA),
        .q     (a_sync)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clock (clock),
        .reset (reset),
        .d     (quadB),
        .q     (b_sync)
    );

    assign step = gray_decode(prev_ab, {a_sync, b_sync});

    always_comb begin
        step_ext = '0;
        case (step)
            STEP_FWD: step_ext = {{W{1'b0}}, 1'b1};
            STEP_REV: step_ext = '1;
            default:  step_ext = '0;
        endcase
    end

    // A wrapped sign bit means the step would leave the range
    assign sum       = {pend_q[W-1], pend_q} + step_ext;
    assign sat       = sum[W] ^ sum[W-1];
    assign pend_base = sat ? pend_q : sum[W-1:0];

    assign pos = !pend_q[W-1] && (|pend_q);
    assign neg = pend_q[W-1];

    assign issue_up   = pos && ((state == IDLE) ||
                        (state == UP_REQ && upAck));
    assign issue_down = neg && ((state == IDLE) ||
                        (state == DOWN_REQ && downAck));

    always_comb begin
        pend_next = pend_base;
        if (issue_up)
            pend_next = pend_base - {{(W-1){1'b0}}, 1'b1};
        else if (issue_down)
            pend_next = pend_base + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_ab  <= 2'b00;
            pend_q   <= '0;
            overflow <= 1'b0;
            glitch   <= 1'b0;
        end else begin
            prev_ab <= {a_sync, b_sync};
            pend_q  <= pend_next;
            if (sat)
                overflow <= 1'b1;
            if (step == STEP_BAD)
                glitch <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            up    <= 1'b0;
            down  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pos) begin
                        state <= UP_REQ;
                        up    <= 1'b1;
                    end else if (neg) begin
                        state <= DOWN_REQ;
                        down  <= 1'b1;
                    end
                end
                UP_REQ: begin
                    if (upAck && !pos) begin
                        state <= IDLE;
                        up    <= 1'b0;
                    end
                end
                DOWN_REQ: begin
                    if (downAck && !neg) begin
                        state <= IDLE;
                        down  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    up    <= 1'b0;
                    down  <= 1'b0;
                end
            endcase
        end
    end

    assign pending = pend_q;

endmodule

// File: tb/tb_quadrature_step_requester.sv
// Directed-vector bench for quadrature_step_requester.
module tb_quadrature_step_requester;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       quadA = 1'b0;
    logic       quadB = 1'b0;
    logic       upAck = 1'b0;
    logic       downAck = 1'b0;
    logic       up;
    logic       down;
    logic [3:0] pending;
    logic       overflow;
    logic       glitch;

    int tests = 0;
    int fails = 0;
    int idx = 0;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quadrature_step_requester #(
        .SYNC_STAGES   (2),
        .PENDING_WIDTH (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .quadA    (quadA),
        .quadB    (quadB),
        .upAck    (upAck),
        .downAck  (downAck),
        .up       (up),
        .down     (down),
        .pending  (pending),
        .overflow (overflow),
        .glitch   (glitch)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic step(input int dir);
        idx = (idx + dir) & 3;
        {quadA, quadB} = gray[idx];
        cyc(2);
    endtask

    task automatic do_reset();
        quadA = 1'b0; quadB = 1'b0; idx = 0;
        upAck = 1'b0; downAck = 1'b0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        quadA = 1'b0; quadB = 1'b0; idx = 0;
        reset = 1'b1;
        cyc(2);
        tests++;
        if ({up, down, pending, overflow, glitch} !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold outs=%h exp=00",
                {up, down, pending, overflow, glitch});
        end
        reset = 1'b0;
        cyc(3);
        tests++;
        if ({up, down, pending, overflow, glitch} !== 8'h00) begin
            fails++;
            $display("FAIL reset_idle outs=%h exp=00",
                {up, down, pending, overflow, glitch});
        end
    endtask

    task automatic test_single_step();
        do_reset();
        step(1);
        cyc(1);
        tests++;
        if (pending !== 4'd1 || up !== 1'b0) begin
            fails++;
            $display("FAIL single_latency pending=%0d up=%0b exp 1/0",
                pending, up);
        end
        cyc(1);
        tests++;
        if (up !== 1'b1 || pending !== 4'd0) begin
            fails++;
            $display("FAIL single_req up=%0b pending=%0d exp 1/0",
                up, pending);
        end
        upAck = 1'b1;
        cyc(1);
        upAck = 1'b0;
        tests++;
        if (up !== 1'b0 || pending !== 4'd0) begin
            fails++;
            $display("FAIL single_ack up=%0b pending=%0d exp 0/0",
                up, pending);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_p [3] = '{4'd2, 4'd1, 4'd0};
        do_reset();
        repeat (4) step(1);
        cyc(3);
        tests++;
        if (pending !== 4'd3 || up !== 1'b1) begin
            fails++;
            $display("FAIL b2b_bank pending=%0d up=%0b exp 3/1",
                pending, up);
        end
        for (int i = 0; i < 3; i++) begin
            upAck = 1'b1;
            cyc(1);
            upAck = 1'b0;
            tests++;
            if (up !== 1'b1 || pending !== exp_p[i]) begin
                fails++;
                $display("FAIL b2b_ack%0d up=%0b pending=%0d exp 1/%0d",
                    i, up, pending, exp_p[i]);
            end
            cyc(1);
        end
        upAck = 1'b1;
        cyc(1);
        upAck = 1'b0;
        tests++;
        if (up !== 1'b0 || down !== 1'b0) begin
            fails++;
            $display("FAIL b2b_last up=%0b down=%0b exp 0/0", up, down);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (8) step(1);
        cyc(3);
        tests++;
        if (pending !== 4'd7 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL sat_full pending=%0d ovf=%0b exp 7/0",
                pending, overflow);
        end
        repeat (2) step(1);
        cyc(3);
        tests++;
        if (pending !== 4'd7 || overflow !== 1'b1 || up !== 1'b1) begin
            fails++;
            $display("FAIL sat_drop pending=%0d ovf=%0b up=%0b exp 7/1/1",
                pending, overflow, up);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        quadA = 1'b1; quadB = 1'b1;
        cyc(5);
        tests++;
        if (glitch !== 1'b1 || pending !== 4'd0 || up !== 1'b0 ||
            down !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL glitch g=%0b pending=%0d up=%0b dn=%0b exp 1/0/0/0",
                glitch, pending, up, down);
        end
        quadA = 1'b0; quadB = 1'b0;
        cyc(5);
        tests++;
        if (glitch !== 1'b1 || pending !== 4'd0) begin
            fails++;
            $display("FAIL glitch_sticky g=%0b pending=%0d exp 1/0",
                glitch, pending);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        step(1); step(1);
        step(-1); step(-1); step(-1);
        cyc(3);
        tests++;
        if (up !== 1'b1 || down !== 1'b0 || pending !== 4'hE) begin
            fails++;
            $display("FAIL rev_hold up=%0b dn=%0b pending=%h exp 1/0/e",
                up, down, pending);
        end
        upAck = 1'b1;
        cyc(1);
        upAck = 1'b0;
        tests++;
        if (up !== 1'b0 || down !== 1'b0 || pending !== 4'hE) begin
            fails++;
            $display("FAIL rev_release up=%0b dn=%0b pending=%h exp 0/0/e",
                up, down, pending);
        end
        cyc(1);
        tests++;
        if (down !== 1'b1 || up !== 1'b0 || pending !== 4'hF) begin
            fails++;
            $display("FAIL rev_down dn=%0b up=%0b pending=%h exp 1/0/f",
                down, up, pending);
        end
        downAck = 1'b1;
        cyc(1);
        downAck = 1'b0;
        tests++;
        if (down !== 1'b1 || pending !== 4'd0) begin
            fails++;
            $display("FAIL rev_ack1 dn=%0b pending=%h exp 1/0",
                down, pending);
        end
        cyc(1);
        downAck = 1'b1;
        cyc(1);
        downAck = 1'b0;
        tests++;
        if (down !== 1'b0 || up !== 1'b0 || pending !== 4'd0) begin
            fails++;
            $display("FAIL rev_ack2 dn=%0b up=%0b pending=%h exp 0/0/0",
                down, up, pending);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (6) step(1);
        cyc(3);
        tests++;
        if (up !== 1'b1 || pending !== 4'd5) begin
            fails++;
            $display("FAIL mid_setup up=%0b pending=%0d exp 1/5",
                up, pending);
        end
        reset = 1'b1;
        quadA = 1'b0; quadB = 1'b0; idx = 0;
        #1;
        tests++;
        if ({up, down, pending, overflow, glitch} !== 8'h00) begin
            fails++;
            $display("FAIL mid_async outs=%h exp=00",
                {up, down, pending, overflow, glitch});
        end
        cyc(2);
        reset = 1'b0;
        cyc(3);
        tests++;
        if (up !== 1'b0 || pending !== 4'd0) begin
            fails++;
            $display("FAIL mid_idle up=%0b pending=%0d exp 0/0",
                up, pending);
        end
        step(1);
        cyc(2);
        tests++;
        if (up !== 1'b1 || pending !== 4'd0) begin
            fails++;
            $display("FAIL mid_restart up=%0b pending=%0d exp 1/0",
                up, pending);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_back_to_back();
        test_saturate();
        test_glitch();
        test_reversal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
